// File: rtl/iagc_controller_if.sv
// Signal bundle between the IAGC controller and its stream/detector/multiplier neighbours.
// The slave modport is the controller's view; master is the surrounding datapath's view.
interface iagc_controller_if #(
  parameter int IAGC_STATUS_SIZE    = 4,
  parameter int AMPLITUDE_DATA_SIZE = 16,
  parameter int GAIN_SIZE           = 16
);
  logic                           i_enable;
  logic                           i_dataValid;
  logic [AMPLITUDE_DATA_SIZE-1:0] i_referenceAmplitude;
  logic [AMPLITUDE_DATA_SIZE-1:0] i_errorAmplitude;
  logic                           i_update;
  logic [AMPLITUDE_DATA_SIZE-1:0] i_tolerance;
  logic [AMPLITUDE_DATA_SIZE-1:0] i_minReference;
  logic [IAGC_STATUS_SIZE-1:0]    o_iagcStatus;
  logic                           o_sample;
  logic [GAIN_SIZE-1:0]           o_gain;
  logic                           o_gainUpdate;
  logic                           o_lowSignal;

  modport master (
    output i_enable, i_dataValid, i_referenceAmplitude, i_errorAmplitude,
           i_update, i_tolerance, i_minReference,
    input  o_iagcStatus, o_sample, o_gain, o_gainUpdate, o_lowSignal
  );

  modport slave (
    input  i_enable, i_dataValid, i_referenceAmplitude, i_errorAmplitude,
           i_update, i_tolerance, i_minReference,
    output o_iagcStatus, o_sample, o_gain, o_gainUpdate, o_lowSignal
  );
endinterface

// File: rtl/iagc_controller.sv
// IAGC sequencer: RESET/INIT/RUN/LOCKED/FAULT state machine, sample strobe generation
// and a direction-reversing step search on the gain word driven by detector windows.
module iagc_controller #(
  parameter int                   IAGC_STATUS_SIZE    = 4,
  parameter int                   AMPLITUDE_DATA_SIZE = 16,
  parameter int                   GAIN_SIZE           = 16,
  parameter logic [GAIN_SIZE-1:0] GAIN_INIT           = 16'h8000,
  parameter logic [GAIN_SIZE-1:0] INITIAL_STEP        = 16'h0100,
  parameter int                   SAMPLE_DIVIDER      = 4,
  parameter int                   INIT_CYCLES         = 16,
  parameter int                   LOCK_WINDOWS        = 4,
  parameter int                   TIMEOUT_WINDOWS     = 64
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  iagc_controller_if.slave  bus
);

  localparam int AW = AMPLITUDE_DATA_SIZE;
  localparam int GW = GAIN_SIZE;
  localparam int BW = (SAMPLE_DIVIDER > 1) ? $clog2(SAMPLE_DIVIDER) : 1;
  localparam int LW = $clog2(LOCK_WINDOWS + 1);
  localparam int WW = $clog2(TIMEOUT_WINDOWS + 1);
  localparam int IW = $clog2(INIT_CYCLES + 1);

  localparam logic [BW-1:0] BEAT_LAST = BW'(SAMPLE_DIVIDER - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WINDOWS - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(TIMEOUT_WINDOWS - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [AW-1:0] ERR_MAX   = {1'b0, {(AW-1){1'b1}}};
  localparam logic [GW-1:0] GAIN_MAX  = '1;
  localparam logic [GW-1:0] STEP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gain_q, gain_d;
  logic [GW-1:0] step_q, step_d;
  logic          dir_up_q, dir_up_d;
  logic [AW-1:0] prev_err_q, prev_err_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          gain_update_q, gain_update_d;
  logic          low_signal_q, low_signal_d;

  logic [AW-1:0] err_clamped;
  logic          ref_low;
  logic          in_tol;
  logic          err_rising;
  logic          dir_adj;
  logic [GW-1:0] step_half;
  logic [GW-1:0] step_adj;
  logic [GW:0]   gain_sum;
  logic [GW-1:0] gain_adj;
  logic          tracking;

  assign tracking = (state_q == ST_RUN) || (state_q == ST_LOCKED);

  // Candidate search step for this window: a worse error than last time reverses
  // direction and halves the step (never below 1) before the gain moves.
  always_comb begin
    err_clamped = bus.i_errorAmplitude[AW-1] ? '0 : bus.i_errorAmplitude;
    ref_low     = $signed(bus.i_referenceAmplitude) < $signed(bus.i_minReference);
    in_tol      = err_clamped <= bus.i_tolerance;
    err_rising  = err_clamped > prev_err_q;
    dir_adj     = err_rising ? ~dir_up_q : dir_up_q;
    step_half   = step_q >> 1;
    step_adj    = step_q;
    if (err_rising) begin
      step_adj = (step_half == '0) ? STEP_ONE : step_half;
    end
    gain_sum = {1'b0, gain_q} + {1'b0, step_adj};
    if (dir_adj) begin
      gain_adj = gain_sum[GW] ? GAIN_MAX : gain_sum[GW-1:0];
    end else begin
      gain_adj = (step_adj > gain_q) ? '0 : (gain_q - step_adj);
    end
  end

  always_comb begin
    state_d       = state_q;
    gain_d        = gain_q;
    step_d        = step_q;
    dir_up_d      = dir_up_q;
    prev_err_d    = prev_err_q;
    lock_cnt_d    = lock_cnt_q;
    win_cnt_d     = win_cnt_q;
    init_cnt_d    = init_cnt_q;
    gain_update_d = 1'b0;
    low_signal_d  = low_signal_q;

    beat_cnt_d = '0;
    if (tracking) begin
      beat_cnt_d = beat_cnt_q;
      if (bus.i_dataValid) begin
        beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? '0 : (beat_cnt_q + 1'b1);
      end
    end

    if (!bus.i_enable || (state_q == ST_RESET) || (state_q == ST_INIT)) begin
      gain_d       = GAIN_INIT;
      step_d       = INITIAL_STEP;
      dir_up_d     = 1'b1;
      prev_err_d   = ERR_MAX;
      lock_cnt_d   = '0;
      win_cnt_d    = '0;
      low_signal_d = 1'b0;
    end

    if (!bus.i_enable) begin
      state_d    = ST_RESET;
      init_cnt_d = '0;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
        ST_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_d    = ST_RUN;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.i_update) begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (ref_low) begin
              low_signal_d = 1'b1;
            end else begin
              low_signal_d = 1'b0;
              if (in_tol) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (lock_cnt_q == LOCK_LAST) begin
                  state_d = ST_LOCKED;
                end
              end else begin
                lock_cnt_d    = '0;
                dir_up_d      = dir_adj;
                step_d        = step_adj;
                gain_d        = gain_adj;
                gain_update_d = (gain_adj != gain_q);
                prev_err_d    = err_clamped;
              end
            end
            // A window that both locks and exhausts the budget counts as a lock.
            if ((state_d != ST_LOCKED) && (win_cnt_q == WIN_LAST)) begin
              state_d = ST_FAULT;
            end
          end
        end
        ST_LOCKED: begin
          if (bus.i_update) begin
            if (ref_low) begin
              low_signal_d = 1'b1;
            end else begin
              low_signal_d = 1'b0;
              if (!in_tol) begin
                state_d    = ST_RUN;
                lock_cnt_d = '0;
                win_cnt_d  = '0;
              end
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q       <= ST_RESET;
      gain_q        <= GAIN_INIT;
      step_q        <= INITIAL_STEP;
      dir_up_q      <= 1'b1;
      prev_err_q    <= ERR_MAX;
      lock_cnt_q    <= '0;
      win_cnt_q     <= '0;
      init_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      gain_update_q <= 1'b0;
      low_signal_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      gain_q        <= gain_d;
      step_q        <= step_d;
      dir_up_q      <= dir_up_d;
      prev_err_q    <= prev_err_d;
      lock_cnt_q    <= lock_cnt_d;
      win_cnt_q     <= win_cnt_d;
      init_cnt_q    <= init_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      gain_update_q <= gain_update_d;
      low_signal_q  <= low_signal_d;
    end
  end

  assign bus.o_iagcStatus = {{(IAGC_STATUS_SIZE-3){1'b0}}, state_q};
  assign bus.o_sample     = bus.i_dataValid && (beat_cnt_q == BEAT_LAST) && tracking;
  assign bus.o_gain       = gain_q;
  assign bus.o_gainUpdate = gain_update_q;
  assign bus.o_lowSignal  = low_signal_q;

endmodule

// File: tb/tb_iagc_controller.sv
// Directed bench for iagc_controller: sequencing, sample strobe, step search,
// lock/unlock, timeout, saturation, enable priority and asynchronous reset.
module tb_iagc_controller;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  iagc_controller_if bus ();

  iagc_controller dut (
    .i_clock  (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  localparam logic [15:0] REF_OK = 16'd2000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [15:0] r, input logic [15:0] e);
    bus.i_referenceAmplitude = r;
    bus.i_errorAmplitude     = e;
    bus.i_update             = 1'b1;
    tick();
    bus.i_update = 1'b0;
    $display("update ref=%0d err=%0d -> status=%0h gain=%h gu=%0b low=%0b",
             $signed(r), $signed(e), bus.o_iagcStatus, bus.o_gain,
             bus.o_gainUpdate, bus.o_lowSignal);
  endtask

  task automatic go_run;
    bus.i_enable    = 1'b0;
    bus.i_dataValid = 1'b0;
    tick();
    bus.i_enable = 1'b1;
    repeat (17) tick();
  endtask

  task automatic test_reset;
    #12;
    checks++; if (bus.o_iagcStatus !== 4'h0) begin errors++; $display("FAIL reset_status: got %h want 0", bus.o_iagcStatus); end
    checks++; if (bus.o_gain !== 16'h8000) begin errors++; $display("FAIL reset_gain: got %h want 8000", bus.o_gain); end
    checks++; if (bus.o_sample !== 1'b0) begin errors++; $display("FAIL reset_sample: got %b want 0", bus.o_sample); end
    checks++; if (bus.o_gainUpdate !== 1'b0) begin errors++; $display("FAIL reset_gu: got %b want 0", bus.o_gainUpdate); end
    checks++; if (bus.o_lowSignal !== 1'b0) begin errors++; $display("FAIL reset_low: got %b want 0", bus.o_lowSignal); end
    tick();
    resetn = 1'b1;
    tick();
    checks++; if (bus.o_iagcStatus !== 4'h0) begin errors++; $display("FAIL idle_status: got %h want 0", bus.o_iagcStatus); end
    bus.i_enable = 1'b1;
    tick();
    begin
      int n;
      n = 0;
      for (int i = 0; i < 40 && bus.o_iagcStatus == 4'h1; i++) begin
        n++;
        tick();
      end
      $display("init lasted %0d cycles", n);
      checks++; if (n != 16) begin errors++; $display("FAIL init_cycles: got %0d want 16", n); end
    end
    checks++; if (bus.o_iagcStatus !== 4'h2) begin errors++; $display("FAIL run_entry: got %h want 2", bus.o_iagcStatus); end
    checks++; if (bus.o_gain !== 16'h8000) begin errors++; $display("FAIL run_gain: got %h want 8000", bus.o_gain); end
  endtask

  task automatic test_sample;
    logic [23:0] pat;
    int cnt;
    logic exp;
    pat = 24'b0101_1100_1101_1111_1111_1111;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      bus.i_dataValid = pat[i];
      #1;
      exp = pat[i] && (cnt == 3);
      $display("beat %0d valid=%0b sample=%0b", i, pat[i], bus.o_sample);
      checks++; if (bus.o_sample !== exp) begin errors++; $display("FAIL sample_%0d: got %b want %b", i, bus.o_sample, exp); end
      if (pat[i]) cnt = (cnt + 1) % 4;
      tick();
    end
    bus.i_dataValid = 1'b0;
  endtask

  task automatic test_gain_search;
    logic [15:0] exp_gain [3];
    logic [15:0] errs [3];
    exp_gain = '{16'h8100, 16'h8200, 16'h8180};
    errs     = '{16'd500, 16'd400, 16'd600};
    go_run();
    for (int i = 0; i < 3; i++) begin
      do_update(REF_OK, errs[i]);
      checks++; if (bus.o_gain !== exp_gain[i]) begin errors++; $display("FAIL search_gain_%0d: got %h want %h", i, bus.o_gain, exp_gain[i]); end
      checks++; if (bus.o_gainUpdate !== 1'b1) begin errors++; $display("FAIL search_gu_%0d: got %b want 1", i, bus.o_gainUpdate); end
    end
    tick();
    checks++; if (bus.o_gainUpdate !== 1'b0) begin errors++; $display("FAIL search_gu_drop: got %b want 0", bus.o_gainUpdate); end
  endtask

  task automatic test_lock;
    for (int i = 0; i < 3; i++) do_update(REF_OK, 16'd50);
    checks++; if (bus.o_iagcStatus !== 4'h2) begin errors++; $display("FAIL lock_early: got %h want 2", bus.o_iagcStatus); end
    checks++; if (bus.o_gain !== 16'h8180 || bus.o_gainUpdate !== 1'b0) begin errors++; $display("FAIL lock_hold: got %h/%b want 8180/0", bus.o_gain, bus.o_gainUpdate); end
    do_update(REF_OK, 16'd50);
    checks++; if (bus.o_iagcStatus !== 4'h3) begin errors++; $display("FAIL lock_4th: got %h want 3", bus.o_iagcStatus); end
    do_update(16'd500, 16'd5000);
    checks++; if (bus.o_iagcStatus !== 4'h3 || bus.o_lowSignal !== 1'b1) begin errors++; $display("FAIL locked_low: got %h/%b want 3/1", bus.o_iagcStatus, bus.o_lowSignal); end
    do_update(REF_OK, 16'd200);
    checks++; if (bus.o_iagcStatus !== 4'h2) begin errors++; $display("FAIL unlock: got %h want 2", bus.o_iagcStatus); end
    checks++; if (bus.o_gain !== 16'h8180 || bus.o_lowSignal !== 1'b0) begin errors++; $display("FAIL unlock_gain: got %h/%b want 8180/0", bus.o_gain, bus.o_lowSignal); end
    for (int i = 0; i < 3; i++) do_update(REF_OK, 16'd50);
    checks++; if (bus.o_iagcStatus !== 4'h2) begin errors++; $display("FAIL relock_count: got %h want 2", bus.o_iagcStatus); end
    do_update(REF_OK, 16'd50);
    checks++; if (bus.o_iagcStatus !== 4'h3) begin errors++; $display("FAIL relock: got %h want 3", bus.o_iagcStatus); end
  endtask

  task automatic test_low_signal;
    go_run();
    do_update(16'd500, 16'd500);
    checks++; if (bus.o_lowSignal !== 1'b1 || bus.o_gain !== 16'h8000 || bus.o_gainUpdate !== 1'b0) begin errors++; $display("FAIL low_set: got %b/%h/%b want 1/8000/0", bus.o_lowSignal, bus.o_gain, bus.o_gainUpdate); end
    do_update(REF_OK, 16'd500);
    checks++; if (bus.o_lowSignal !== 1'b0 || bus.o_gain !== 16'h8100) begin errors++; $display("FAIL low_clear: got %b/%h want 0/8100", bus.o_lowSignal, bus.o_gain); end
    do_update(16'd1000, 16'd500);
    checks++; if (bus.o_lowSignal !== 1'b0 || bus.o_gain !== 16'h8200) begin errors++; $display("FAIL ref_equal_min: got %b/%h want 0/8200", bus.o_lowSignal, bus.o_gain); end
    do_update(16'h8000, 16'd500);
    checks++; if (bus.o_lowSignal !== 1'b1 || bus.o_gain !== 16'h8200) begin errors++; $display("FAIL ref_negative: got %b/%h want 1/8200", bus.o_lowSignal, bus.o_gain); end
    do_update(REF_OK, 16'hFF00);
    checks++; if (bus.o_gain !== 16'h8200 || bus.o_gainUpdate !== 1'b0 || bus.o_iagcStatus !== 4'h2) begin errors++; $display("FAIL neg_err_clamp: got %h/%b/%h want 8200/0/2", bus.o_gain, bus.o_gainUpdate, bus.o_iagcStatus); end
  endtask

  task automatic test_timeout;
    go_run();
    for (int i = 0; i < 63; i++) do_update(REF_OK, 16'd500);
    checks++; if (bus.o_iagcStatus !== 4'h2 || bus.o_gain !== 16'hBF00) begin errors++; $display("FAIL timeout_63: got %h/%h want 2/bf00", bus.o_iagcStatus, bus.o_gain); end
    do_update(REF_OK, 16'd500);
    checks++; if (bus.o_iagcStatus !== 4'h4 || bus.o_gain !== 16'hC000) begin errors++; $display("FAIL timeout_64: got %h/%h want 4/c000", bus.o_iagcStatus, bus.o_gain); end
    do_update(REF_OK, 16'd300);
    do_update(REF_OK, 16'd900);
    do_update(REF_OK, 16'd50);
    checks++; if (bus.o_iagcStatus !== 4'h4 || bus.o_gain !== 16'hC000 || bus.o_gainUpdate !== 1'b0) begin errors++; $display("FAIL fault_frozen: got %h/%h/%b want 4/c000/0", bus.o_iagcStatus, bus.o_gain, bus.o_gainUpdate); end
    bus.i_enable = 1'b0;
    tick();
    checks++; if (bus.o_iagcStatus !== 4'h0 || bus.o_gain !== 16'h8000) begin errors++; $display("FAIL fault_exit: got %h/%h want 0/8000", bus.o_iagcStatus, bus.o_gain); end
    bus.i_enable = 1'b1;
  endtask

  task automatic test_saturation;
    go_run();
    for (int i = 0; i < 60; i++) do_update(REF_OK, 16'd500);
    checks++; if (bus.o_gain !== 16'hBC00) begin errors++; $display("FAIL sat_ramp1: got %h want bc00", bus.o_gain); end
    for (int i = 0; i < 4; i++) do_update(REF_OK, 16'd50);
    checks++; if (bus.o_iagcStatus !== 4'h3) begin errors++; $display("FAIL lock_beats_timeout: got %h want 3", bus.o_iagcStatus); end
    do_update(REF_OK, 16'd500);
    for (int i = 0; i < 60; i++) do_update(REF_OK, 16'd500);
    checks++; if (bus.o_gain !== 16'hF800 || bus.o_iagcStatus !== 4'h2) begin errors++; $display("FAIL sat_ramp2: got %h/%h want f800/2", bus.o_gain, bus.o_iagcStatus); end
    for (int i = 0; i < 4; i++) do_update(REF_OK, 16'd50);
    do_update(REF_OK, 16'd500);
    for (int i = 0; i < 7; i++) do_update(REF_OK, 16'd500);
    checks++; if (bus.o_gain !== 16'hFF00) begin errors++; $display("FAIL sat_ramp3: got %h want ff00", bus.o_gain); end
    do_update(REF_OK, 16'd500);
    checks++; if (bus.o_gain !== 16'hFFFF || bus.o_gainUpdate !== 1'b1) begin errors++; $display("FAIL sat_top: got %h/%b want ffff/1", bus.o_gain, bus.o_gainUpdate); end
    do_update(REF_OK, 16'd500);
    checks++; if (bus.o_gain !== 16'hFFFF || bus.o_gainUpdate !== 1'b0) begin errors++; $display("FAIL sat_hold: got %h/%b want ffff/0", bus.o_gain, bus.o_gainUpdate); end
  endtask

  task automatic test_enable_priority;
    go_run();
    do_update(REF_OK, 16'd500);
    do_update(REF_OK, 16'd400);
    checks++; if (bus.o_gain !== 16'h8200) begin errors++; $display("FAIL prio_setup: got %h want 8200", bus.o_gain); end
    bus.i_enable = 1'b0;
    do_update(REF_OK, 16'd300);
    checks++; if (bus.o_iagcStatus !== 4'h0 || bus.o_gain !== 16'h8000 || bus.o_gainUpdate !== 1'b0) begin errors++; $display("FAIL enable_priority: got %h/%h/%b want 0/8000/0", bus.o_iagcStatus, bus.o_gain, bus.o_gainUpdate); end
    bus.i_enable = 1'b1;
  endtask

  task automatic test_async_reset;
    go_run();
    do_update(REF_OK, 16'd500);
    bus.i_dataValid = 1'b1;
    repeat (3) tick();
    checks++; if (bus.o_sample !== 1'b1) begin errors++; $display("FAIL async_pre_sample: got %b want 1", bus.o_sample); end
    resetn = 1'b0;
    #1;
    $display("async reset asserted: status=%0h gain=%h sample=%0b", bus.o_iagcStatus, bus.o_gain, bus.o_sample);
    checks++; if (bus.o_sample !== 1'b0) begin errors++; $display("FAIL async_sample: got %b want 0", bus.o_sample); end
    checks++; if (bus.o_iagcStatus !== 4'h0 || bus.o_gain !== 16'h8000) begin errors++; $display("FAIL async_state: got %h/%h want 0/8000", bus.o_iagcStatus, bus.o_gain); end
    tick();
    bus.i_dataValid = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_enable             = 1'b0;
    bus.i_dataValid          = 1'b0;
    bus.i_referenceAmplitude = REF_OK;
    bus.i_errorAmplitude     = '0;
    bus.i_update             = 1'b0;
    bus.i_tolerance          = 16'd100;
    bus.i_minReference       = 16'd1000;
    test_reset();
    test_sample();
    test_gain_search();
    test_lock();
    test_low_signal();
    test_timeout();
    test_saturation();
    test_enable_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iagc_controller.md
# iagc_controller

Sequencer and gain-loop controller for the IAGC datapath. Drives the 4-bit IAGC status bus and the per-beat sample strobe consumed by the amplitude detector. Consumes the detector's per-window reference/error amplitudes and update pulse, and adjusts a gain word by direction-reversing step search until the error amplitude stays within tolerance. Sits between the AXI-Stream input stage, the amplitude detector and the gain-applying multiplier.

## Interface
- IAGC_STATUS_SIZE, 4, width of status bus
- AMPLITUDE_DATA_SIZE, 16, width of signed amplitude inputs
- GAIN_SIZE, 16, width of unsigned gain word
- GAIN_INIT, 16'h8000, gain loaded in RESET/INIT
- INITIAL_STEP, 16'h0100, step loaded in RESET/INIT
- SAMPLE_DIVIDER, 4, valid beats per sample strobe (≥1)
- INIT_CYCLES, 16, cycles spent in INIT (≥1)
- LOCK_WINDOWS, 4, consecutive in-tolerance windows to declare lock
- TIMEOUT_WINDOWS, 64, RUN windows without lock before FAULT
- i_clock  in  1  system clock, all logic on rising edge
- i_resetn  in  1  reset, asynchronous, active-low
- i_enable  in  1  level; high runs the loop, low forces RESET
- i_dataValid  in  1  input stream beat valid
- i_referenceAmplitude  in  AMPLITUDE_DATA_SIZE  signed, window reference amplitude
- i_errorAmplitude  in  AMPLITUDE_DATA_SIZE  signed, window error amplitude
- i_update  in  1  one-cycle pulse, amplitudes valid
- i_tolerance  in  AMPLITUDE_DATA_SIZE  unsigned error threshold
- i_minReference  in  AMPLITUDE_DATA_SIZE  unsigned minimum usable reference
- o_iagcStatus  out  IAGC_STATUS_SIZE  RESET=0000, INIT=0001, RUN=0010, LOCKED=0011, FAULT=0100
- o_sample  out  1  sample strobe to detector
- o_gain  out  GAIN_SIZE  current gain
- o_gainUpdate  out  1  one-cycle pulse, gain changed
- o_lowSignal  out  1  last window had reference below i_minReference

## Operation
- Reset values: o_iagcStatus=RESET, o_gain=GAIN_INIT, step=INITIAL_STEP, direction=up, o_sample=0, o_gainUpdate=0, o_lowSignal=0, all counters 0, prevError=max positive.
- RESET: gain/step/direction/prevError/counters reloaded; i_enable=1 -> INIT.
- INIT: same reloads; exactly INIT_CYCLES cycles, then RUN.
- RUN, on i_update: e = i_errorAmplitude, negatives clamped to 0; windowCount++.
  - If i_referenceAmplitude < i_minReference (signed compare): set o_lowSignal, no gain change, lockCount unchanged.
  - Else clear o_lowSignal. If e ≤ i_tolerance: lockCount++, gain held; lockCount reaching LOCK_WINDOWS -> LOCKED.
  - Else: lockCount=0. If e > prevError (strict), flip direction and step = max(step>>1, 1). Then gain ± step, saturating at 0 and 2^GAIN_SIZE−1; o_gainUpdate pulses only if value changes. prevError <= e.
  - Lock and timeout on the same update: lock wins. Otherwise windowCount reaching TIMEOUT_WINDOWS -> FAULT.
- LOCKED: gain held. An update with usable reference and e > i_tolerance -> RUN with lockCount=0 and windowCount=0. Gain, step, direction and prevError are kept. Low-signal windows only set o_lowSignal.
- FAULT: gain held, updates ignored, exit only via i_enable=0.
- i_enable=0 in any state -> RESET next edge. This takes priority over a same-cycle i_update.
- i_update in RESET/INIT/FAULT is ignored.
- o_sample is combinational: i_dataValid && beatCount==SAMPLE_DIVIDER−1 && state∈{RUN, LOCKED}.
  - beatCount advances on each valid beat in RUN/LOCKED and wraps at SAMPLE_DIVIDER−1.
  - beatCount is forced to 0 in other states.

## Timing
- Status, gain, o_gainUpdate and o_lowSignal are registered. They reflect an i_update on the edge that samples it (1-cycle latency).
- o_sample has zero latency from i_dataValid. Its first strobe is on the SAMPLE_DIVIDER-th valid beat after entering RUN.
- INIT→RUN transition occurs INIT_CYCLES edges after entering INIT.
- Back-to-back i_update pulses are each processed; there is no minimum spacing.
- Asynchronous reset mid-window: all state returns to reset values immediately, and o_sample drops combinationally.

## Test plan
- Reset, i_enable=1, INIT_CYCLES=16 -> status 0000, 0001 for 16 cycles, then 0010; gain 0x8000.
- RUN, continuous i_dataValid, SAMPLE_DIVIDER=4 -> o_sample high every 4th cycle; dataValid gaps stretch the period accordingly.
- Tolerance 100; errors 500, 400, 600 -> gain 0x8100, 0x8200, then flip: step 0x80, gain 0x8180; o_gainUpdate pulses ×3.
- Errors 50 ×4 with reference ≥ i_minReference -> LOCKED (0011) after the 4th update; a following error 200 -> RUN, lockCount 0.
- 64 out-of-tolerance updates -> FAULT (0100). Gain then frozen under further updates; i_enable=0 -> RESET, gain 0x8000.
- Gain saturation: gain 0xFF80 at step 0x100 going up -> 0xFFFF. i_enable=0 coincident with i_update -> RESET, no gain change.
